// File: rtl/topo_pkg.sv
// Shared types and helpers for the topology switch blocks in the reconfigurable fabric.
package topo_pkg;

  localparam int TOPO_N = 7;
  localparam int TOPO_W = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Out-of-range selects fall back to the last channel, as the legacy selectors did.
  function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned n);
    return (sel >= n) ? n - 1 : sel;
  endfunction

endpackage

// File: rtl/topo_out_reg.sv
// Single-entry W-bit output register with valid/ready hold; data and valid are frozen while stalled.
module topo_out_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/topo_mux_n.sv
// N:1 flow-controlled channel selector that drains the output slot before switching channel.
// Define TOPO_MUX_XFER_CNT_EN to build the accepted-beat counter on xfer_cnt.
module topo_mux_n
  import topo_pkg::*;
#(
  parameter  int N       = TOPO_N,
  parameter  int W       = TOPO_W,
  parameter  int SEL_RST = 0,
  localparam int SW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] din,
  input  logic [N-1:0]   din_valid,
  output logic [N-1:0]   din_ready,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  input  logic           cfg_valid,
  input  logic [SW-1:0]  cfg_sel,
  output logic           cfg_ready,
  output logic [SW-1:0]  cur_sel,
  output logic           cfg_done,
  output logic           cfg_err,
  output logic [31:0]    xfer_cnt
);

  state_t              state_q, state_d;
  logic [SW-1:0]       cur_sel_q, cur_sel_d, pend_sel_q, pend_sel_d;
  logic                cfg_err_q, cfg_err_d;
  logic                out_free, beat_acc;
  logic [N-1:0][W-1:0] din_ch;

  assign din_ch   = din;
  assign beat_acc = din_valid[cur_sel_q] && din_ready[cur_sel_q];
  assign cur_sel  = cur_sel_q;
  assign cfg_err  = cfg_err_q;

  topo_out_reg #(.W(W)) u_out (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (beat_acc),
    .in_data_i   (din_ch[cur_sel_q]),
    .in_ready_o  (out_free),
    .out_valid_o (dout_valid),
    .out_data_o  (dout),
    .out_ready_i (dout_ready)
  );

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    cfg_err_d  = 1'b0;
    din_ready  = '0;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A beat taken alongside the config still uses the old cur_sel.
        din_ready[cur_sel_q] = out_free && !rst;
        cfg_ready            = !rst;
        if (cfg_valid && cfg_ready) begin
          pend_sel_d = SW'(sel_clamp(32'(cfg_sel), 32'(N)));
          cfg_err_d  = 32'(cfg_sel) >= 32'(N);
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_free) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        cur_sel_d = pend_sel_q;
        cfg_done  = !rst;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cur_sel_q  <= SW'(SEL_RST);
      pend_sel_q <= SW'(SEL_RST);
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef TOPO_MUX_XFER_CNT_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (state_q == ST_SWITCH) xfer_cnt_d = '0;
    else if (beat_acc)        xfer_cnt_d = xfer_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_topo_mux_n.sv
// Self-checking bench for topo_mux_n: table-driven streaming/backpressure plus reconfig sequences.
module tb_topo_mux_n;
  localparam int N  = 7;
  localparam int W  = 8;
  localparam int SW = 3;
`ifdef TOPO_MUX_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] din;
  logic [N-1:0]   din_valid, din_ready;
  logic [W-1:0]   dout;
  logic           dout_valid, dout_ready, cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [SW-1:0]  cfg_sel, cur_sel;
  logic [31:0]    xfer_cnt;

  topo_mux_n #(.N(N), .W(W), .SEL_RST(0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(cfg_ready),
    .cur_sel(cur_sel), .cfg_done(cfg_done), .cfg_err(cfg_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v, input logic vld);
    din[ch*W +: W] = v;
    din_valid[ch]  = vld;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input handshake, pop on output handshake; also watch stall stability.
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_d = '0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (din_valid[i] && din_ready[i]) sb_q.push_back(din[i*W +: W]);
      chk("ready_onehot", ($countones(din_ready) <= 1), 1);
      if (stall_q) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_data", dout, stall_d);
      end
      if (dout_valid && dout_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_extra: got beat 0x%0h, expected none at %0t", dout, $time);
        end else begin
          chk("sb_data", dout, sb_q.pop_front());
        end
      end
      stall_q = dout_valid && !dout_ready;
      stall_d = dout;
    end else begin
      stall_q = 1'b0;
      sb_q.delete();
    end
  end

  typedef struct {
    logic [W-1:0] d0;
    logic         v0;
    logic         rdy;
    logic         er0;
    logic         edv;
    logic [W-1:0] edo;
  } vec_t;

  vec_t tbl[24];

  initial begin
    for (int k = 0; k < 16; k++)
      tbl[k] = '{8'(8'h10 + k), 1'b1, 1'b1, 1'b1, (k > 0), (k > 0) ? 8'(8'h10 + k - 1) : 8'h00};
    tbl[16] = '{8'h21, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1F};
    for (int k = 17; k < 21; k++)
      tbl[k] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21};
    tbl[21] = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21};
    tbl[22] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[23] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22};

    // Reset hold with every input valid.
    rst = 1'b1; din = {N{8'hEE}}; din_valid = '1; dout_ready = 1'b1;
    cfg_valid = 1'b0; cfg_sel = '0;
    repeat (2) begin
      mid();
      chk("rst_dout", dout, 0);
      chk("rst_dvalid", dout_valid, 0);
      chk("rst_cur_sel", cur_sel, 0);
      chk("rst_din_ready", din_ready, 0);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_xfer", xfer_cnt, 0);
      nxt();
    end
    rst = 1'b0; din_valid = '0;
    mid();
    chk("post_rst_ready", din_ready, 7'b0000001);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    nxt();

    // Streaming and backpressure on channel 0.
    for (int k = 0; k < 24; k++) begin
      set_ch(0, tbl[k].d0, tbl[k].v0);
      dout_ready = tbl[k].rdy;
      mid();
      chk($sformatf("tbl%0d_ready", k), din_ready, 7'(tbl[k].er0));
      chk($sformatf("tbl%0d_dvalid", k), dout_valid, tbl[k].edv);
      chk($sformatf("tbl%0d_dout", k), dout, tbl[k].edo);
      nxt();
    end
    chk("xfer_stream", xfer_cnt, CNT_EN ? 18 : 0);

    // Reconfig to channel 3 while the output is stalled.
    set_ch(0, 8'h30, 1'b1); dout_ready = 1'b0;
    mid(); chk("A_ready", din_ready, 7'b0000001); nxt();
    set_ch(0, 8'h31, 1'b0); cfg_valid = 1'b1; cfg_sel = 3'd3;
    mid();
    chk("B_cfg_ready", cfg_ready, 1);
    chk("B_dout", dout, 8'h30);
    chk("B_din_ready", din_ready, 0);
    nxt();
    cfg_valid = 1'b0; set_ch(0, 8'h31, 1'b1); set_ch(3, 8'hA5, 1'b1);
    repeat (2) begin
      mid();
      chk("drain_cfg_ready", cfg_ready, 0);
      chk("drain_din_ready", din_ready, 0);
      chk("drain_cfg_done", cfg_done, 0);
      nxt();
    end
    dout_ready = 1'b1;
    mid(); chk("E_cfg_done", cfg_done, 0); chk("E_din_ready", din_ready, 0); nxt();
    mid(); chk("F_cfg_done", cfg_done, 1); chk("F_din_ready", din_ready, 0); chk("F_dvalid", dout_valid, 0); nxt();
    mid();
    chk("G_cur_sel", cur_sel, 3);
    chk("G_cfg_done", cfg_done, 0);
    chk("G_din_ready", din_ready, 7'b0001000);
    chk("G_cfg_ready", cfg_ready, 1);
    chk("G_xfer", xfer_cnt, 0);
    nxt();
    set_ch(3, 8'h00, 1'b0); set_ch(0, 8'h00, 1'b0);
    mid(); chk("H_dout", dout, 8'hA5); chk("H_dvalid", dout_valid, 1); chk("H_xfer", xfer_cnt, CNT_EN ? 1 : 0); nxt();

    // Out-of-range select with a same-cycle beat on the old channel.
    cfg_valid = 1'b1; cfg_sel = 3'd7; set_ch(3, 8'hB3, 1'b1);
    mid(); chk("I_cfg_ready", cfg_ready, 1); chk("I_din_ready", din_ready, 7'b0001000); nxt();
    cfg_valid = 1'b0; set_ch(3, 8'h00, 1'b0);
    mid(); chk("J_cfg_err", cfg_err, 1); chk("J_dout", dout, 8'hB3); chk("J_din_ready", din_ready, 0); nxt();
    mid(); chk("K_cfg_err", cfg_err, 0); chk("K_cfg_done", cfg_done, 1); nxt();
    for (int b = 0; b < 5; b++) begin
      set_ch(6, 8'(8'h60 + b), 1'b1);
      mid();
      if (b == 0) chk("L_cur_sel", cur_sel, 6);
      chk("L_din_ready", din_ready, 7'b1000000);
      nxt();
    end
    set_ch(6, 8'h00, 1'b0);
    mid(); chk("L_dout", dout, 8'h64); chk("L_xfer", xfer_cnt, CNT_EN ? 5 : 0); nxt();

    // Reconfig to the current channel still pulses cfg_done.
    cfg_valid = 1'b1; cfg_sel = 3'd6;
    mid(); nxt();
    cfg_valid = 1'b0;
    mid(); chk("same_drain_done", cfg_done, 0); nxt();
    mid(); chk("same_done", cfg_done, 1); nxt();
    mid(); chk("same_cur_sel", cur_sel, 6); chk("same_err", cfg_err, 0); nxt();

    // Reset in the middle of a drain with a stalled beat.
    set_ch(6, 8'h77, 1'b1); dout_ready = 1'b0;
    mid(); nxt();
    set_ch(6, 8'h00, 1'b0); cfg_valid = 1'b1; cfg_sel = 3'd2;
    mid(); nxt();
    cfg_valid = 1'b0; rst = 1'b1;
    mid(); nxt();
    mid();
    chk("rst2_dvalid", dout_valid, 0);
    chk("rst2_dout", dout, 0);
    chk("rst2_cur_sel", cur_sel, 0);
    nxt();
    rst = 1'b0; dout_ready = 1'b1;
    mid(); chk("rst2_ready", din_ready, 7'b0000001); chk("rst2_xfer", xfer_cnt, 0); nxt();

    mid();
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
